md_unit: RTL and testbench

Multiply/divide unit for the 5-stage pipeline: the producer of the HI/LO values that the E-stage result mux selects onto the ALU output path. It accepts forwarded operands in E and computes mult, multu, div or divu with a fixed multi-cycle latency. It also handles mthi/mtlo writes, holds the HI and LO architectural registers, and drives `busy` so the hazard unit can stall later md-type instructions in D.

---
 rtl/md_unit_pkg.sv | 36 +++
 rtl/md_div.sv | 80 ++++++++
 rtl/md_unit.sv | 131 +++++++++++++
 tb/tb_md_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared opcode/state types, default cycle counts and helpers for the
// multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSVD6 = 3'd6,
    MD_RSVD7 = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;
  localparam int MD_DIV_BITS = 32;

  // Quotient bits retired per clock so all 32 finish before the commit edge,
  // which reads divider state registered one edge earlier.
  function automatic int divIters(input int cycles);
    if (cycles < 2) return MD_DIV_BITS;
    return (MD_DIV_BITS + cycles - 2) / (cycles - 1);
  endfunction

  function automatic logic [31:0] absVal(input logic [31:0] v, input logic en);
    return (en && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/md_div.sv
// Restoring divider on operand magnitudes, retiring ITERS quotient bits per
// clock; signs are reapplied on the way out (quotient truncates toward zero).
module md_div
  import md_unit_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic        r_active;
  logic [5:0]  r_iter;
  logic [31:0] r_q;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_q_nxt;
  logic [31:0] w_rem_nxt;
  logic [5:0]  w_iter_nxt;
  logic [32:0] w_trial;

  // r_q doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    w_q_nxt    = r_q;
    w_rem_nxt  = r_rem;
    w_iter_nxt = r_iter;
    w_trial    = '0;
    for (int k = 0; k < ITERS; k++) begin
      if (r_active && (w_iter_nxt < 6'd32)) begin
        w_trial = {w_rem_nxt, w_q_nxt[31]};
        w_q_nxt = {w_q_nxt[30:0], 1'b0};
        if (w_trial >= {1'b0, r_dvs}) begin
          w_trial    = w_trial - {1'b0, r_dvs};
          w_q_nxt[0] = 1'b1;
        end
        w_rem_nxt  = w_trial[31:0];
        w_iter_nxt = w_iter_nxt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_iter   <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_iter   <= '0;
      r_q      <= absVal(i_dividend, i_signed);
      r_rem    <= '0;
      r_dvs    <= absVal(i_divisor, i_signed);
      r_neg_q  <= i_signed & (i_dividend[31] ^ i_divisor[31]);
      r_neg_r  <= i_signed & i_dividend[31];
    end else if (r_active) begin
      r_q      <= w_q_nxt;
      r_rem    <= w_rem_nxt;
      r_iter   <= w_iter_nxt;
      r_active <= (w_iter_nxt != 6'd32);
    end
  end

  assign o_quot = r_neg_q ? -r_q : r_q;
  assign o_rem  = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: fixed-latency mult/div with a busy flag for the
// hazard unit, plus single-cycle mthi/mtlo writes.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYC,
  parameter int DIV_CYCLES  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam int DIV_ITERS = divIters(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        r_state;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_pend;
  logic             r_is_div;
  logic             r_div_zero;

  md_op_e      w_op;
  logic        w_is_div;
  logic        w_mul_signed;
  logic        w_div_start;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_op         = md_op_e'(md_op);
  assign w_is_div     = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_mul_signed = (w_op == MD_MULT);
  assign w_div_start  = (r_state == ST_IDLE) && md_en && w_is_div;

  // Sign- or zero-extending to 64 bits lets one truncated multiply serve both.
  assign w_a_ext = {{32{w_mul_signed & a[31]}}, a};
  assign w_b_ext = {{32{w_mul_signed & b[31]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  md_div #(
    .ITERS(DIV_ITERS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_div_start),
    .i_signed  (w_op == MD_DIV),
    .i_dividend(a),
    .i_divisor (b),
    .o_quot    (w_quot),
    .o_rem     (w_rem)
  );

  // Ops arriving while RUN, including on the commit edge, are dropped; the
  // hazard unit is responsible for holding them in D.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (md_en) begin
            case (w_op)
              MD_MULT, MD_MULTU: begin
                r_pend     <= w_prod;
                r_count    <= MULT_LOAD;
                r_is_div   <= 1'b0;
                r_div_zero <= 1'b0;
                r_busy     <= 1'b1;
                r_state    <= ST_RUN;
              end
              MD_DIV, MD_DIVU: begin
                r_count    <= DIV_LOAD;
                r_is_div   <= 1'b1;
                r_div_zero <= (b == 32'd0);
                r_busy     <= 1'b1;
                r_state    <= ST_RUN;
              end
              MD_MTHI: r_hi <= a;
              MD_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (r_count == CNT_ONE) begin
            if (!r_div_zero) begin
              {r_hi, r_lo} <= r_is_div ? {w_rem, w_quot} : r_pend;
            end
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count - CNT_ONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle-level reference model checked every
// cycle, plus directed vectors with hand-computed HI/LO values.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_en;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md_en(md_en),
    .md_op(md_op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural HI/LO, cycles left in flight, and the
  // result to land when that count runs out.
  logic [31:0] mHi   = '0;
  logic [31:0] mLo   = '0;
  logic [63:0] mPend = '0;
  int          mLeft = 0;
  bit          mDz   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mHi = '0; mLo = '0; mPend = '0; mLeft = 0; mDz = 1'b0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && !mDz) {mHi, mLo} = mPend;
    end else if (md_en) begin
      case (md_op)
        3'd0: begin
          mPend = longint'($signed(a)) * longint'($signed(b));
          mLeft = 5; mDz = 1'b0;
        end
        3'd1: begin
          mPend = {32'd0, a} * {32'd0, b};
          mLeft = 5; mDz = 1'b0;
        end
        3'd2: begin
          mDz = (b == 0);
          if (!mDz) mPend = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
          mLeft = 10;
        end
        3'd3: begin
          mDz = (b == 0);
          if (!mDz) mPend = {a % b, a / b};
          mLeft = 10;
        end
        3'd4: mHi = a;
        3'd5: mLo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      total++;
      if (busy !== 1'(mLeft > 0)) begin
        bad++;
        $display("[TB] FAIL model_busy: got %b expected %b", busy, mLeft > 0);
      end
      total++;
      if (hi !== mHi) begin
        bad++;
        $display("[TB] FAIL model_hi: got %h expected %h", hi, mHi);
      end
      total++;
      if (lo !== mLo) begin
        bad++;
        $display("[TB] FAIL model_lo: got %h expected %h", lo, mLo);
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expHi,
                             input logic [31:0] expLo, input logic expBusy);
    checkVal({name, "_hi"}, hi, expHi);
    checkVal({name, "_lo"}, lo, expLo);
    checkVal({name, "_busy"}, {31'd0, busy}, {31'd0, expBusy});
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    md_en = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    md_en = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input int expLen,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    applyStimulus(op, av, bv);
    waitIdle(n);
    checkVal({name, "_len"}, n, expLen);
    checkOutput(name, expHi, expLo, 1'b0);
  endtask

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; md_en = 1'b0; md_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chkEn = 1'b1;
    reset = 1'b0;
    checkOutput("reset", 32'h0, 32'h0, 1'b0);

    runOp("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("multu",    3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    runOp("div_neg",  3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    applyStimulus(3'd4, 32'h11, 32'h0);
    checkVal("mthi", hi, 32'h11);
    applyStimulus(3'd5, 32'h22, 32'h0);
    checkVal("mtlo", lo, 32'h22);
    runOp("divu_zero", 3'd3, 32'd7, 32'd0, 10, 32'h11, 32'h22);

    // mthi while a multiply is in flight must be dropped
    applyStimulus(3'd0, 32'h0001_0000, 32'h0003_0000);
    @(negedge clk);
    md_en = 1'b1; md_op = 3'd4; a = 32'hAAAA; b = 32'h0;
    @(negedge clk);
    md_en = 1'b0;
    waitIdle(n);
    checkOutput("mthi_busy", 32'h3, 32'h0, 1'b0);

    applyStimulus(3'd5, 32'h1234, 32'h0);
    checkOutput("mtlo_idle", 32'h3, 32'h1234, 1'b0);
    applyStimulus(3'd6, 32'hDEAD, 32'hBEEF);
    checkOutput("rsvd", 32'h3, 32'h1234, 1'b0);

    // mtlo held across the commit edge lands only on the following edge
    applyStimulus(3'd0, 32'd6, 32'd7);
    md_en = 1'b1; md_op = 3'd5; a = 32'h55; b = 32'h0;
    waitIdle(n);
    checkOutput("commit_edge", 32'h0, 32'h2A, 1'b0);
    @(negedge clk);
    md_en = 1'b0;
    checkVal("after_commit_lo", lo, 32'h55);

    runOp("div_m100_7", 3'd2, 32'hFFFF_FF9C, 32'd7, 10, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    runOp("div_100_m7", 3'd2, 32'd100, 32'hFFFF_FFF9, 10, 32'h0000_0002, 32'hFFFF_FFF2);
    runOp("divu_big",   3'd3, 32'hFFFF_FFFF, 32'h10, 10, 32'h0000_000F, 32'h0FFF_FFFF);
    runOp("mult_min",   3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (rop == 3'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      applyStimulus(rop, ra, rb);
      waitIdle(n);
    end

    // reset in the middle of a divide discards the result
    applyStimulus(3'd4, 32'h77, 32'h0);
    applyStimulus(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_mid", 32'h0, 32'h0, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("no_commit", 32'h0, 32'h0, 1'b0);

    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
